undolog_copy_sequencer: RTL

Command-driven sequencer for the undo-log datapath. It takes one LOG command, reads a block of source words through a single shared memory port, and copies them into a circular log region. It then writes the entry's header word last, so a partially copied entry is never marked valid. It sits behind the AXI4-Lite register front end of the undolog IP, which issues commands and collects responses.

---
 rtl/undolog_copy_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/undolog_copy_sequencer.sv
// Undo-log copy sequencer: copies a block of source words into a circular log
// region through one shared memory port, writing the entry header last.
module undolog_copy_sequencer #(
  parameter logic [31:0] LOG_BASE  = 32'h0001_0000,
  parameter int unsigned LOG_DEPTH = 256,
  parameter int unsigned LOG_AW    = $clog2(LOG_DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_addr,
  input  logic [7:0]        cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [LOG_AW-1:0] rsp_slot,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [LOG_AW:0]   log_used
);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_FULL    = 2'b01;
  localparam logic [1:0] ST_BAD_LEN = 2'b10;
  localparam logic [1:0] ST_BAD_OP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_HDR_REQ,
    S_RESP
  } state_t;

  state_t              state;
  logic [LOG_AW-1:0]   wptr_q;
  logic [LOG_AW:0]     used_q;
  logic [LOG_AW-1:0]   hdr_q;
  logic [7:0]          cnt_q;
  logic [7:0]          len_q;
  logic [31:0]         src_q;

  logic [31:0]         used_need;
  logic [31:0]         cmd_src;
  logic [LOG_AW-1:0]   data_idx;
  logic [31:0]         data_addr;
  logic [31:0]         next_rd_addr;

  assign cmd_ready = (state == S_IDLE) && !ARESET;
  assign busy      = (state != S_IDLE);
  assign log_used  = used_q;

  always_comb begin
    used_need    = 32'(used_q) + 32'(cmd_len) + 32'd1;
    cmd_src      = cmd_addr & ~32'd3;
    data_idx     = LOG_AW'(32'(hdr_q) + 32'(cnt_q) + 32'd1);
    data_addr    = LOG_BASE + (32'(data_idx) << 2);
    next_rd_addr = src_q + (32'(cnt_q) << 2) + 32'd4;
  end

  // Memory-port outputs are registered: each transition loads the values the
  // next state presents, so they hold stable while a request waits for grant.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= S_IDLE;
      wptr_q     <= '0;
      used_q     <= '0;
      hdr_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      src_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_slot   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op[1]) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BAD_OP;
              rsp_slot   <= '0;
              state      <= S_RESP;
            end else if (cmd_op[0]) begin
              used_q     <= '0;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_OK;
              rsp_slot   <= '0;
              state      <= S_RESP;
            end else if (cmd_len == 8'd0) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BAD_LEN;
              rsp_slot   <= '0;
              state      <= S_RESP;
            end else if (used_need > 32'(LOG_DEPTH)) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_FULL;
              rsp_slot   <= '0;
              state      <= S_RESP;
            end else begin
              src_q    <= cmd_src;
              len_q    <= cmd_len;
              hdr_q    <= wptr_q;
              cnt_q    <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= cmd_src;
              state    <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            mem_wdata <= mem_rdata;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= data_addr;
            state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (mem_gnt) begin
            if (cnt_q == len_q - 8'd1) begin
              mem_addr  <= LOG_BASE + (32'(hdr_q) << 2);
              mem_wdata <= {8'hA5, len_q, src_q[17:2]};
              state     <= S_HDR_REQ;
            end else begin
              cnt_q    <= cnt_q + 8'd1;
              mem_we   <= 1'b0;
              mem_addr <= next_rd_addr;
              state    <= S_RD_REQ;
            end
          end
        end
        S_HDR_REQ: begin
          if (mem_gnt) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            wptr_q     <= LOG_AW'(32'(wptr_q) + 32'(len_q) + 32'd1);
            used_q     <= (LOG_AW+1)'(32'(used_q) + 32'(len_q) + 32'd1);
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            rsp_slot   <= hdr_q;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_slot   <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
